// File: rtl/ibuf_pingpong_if.sv
// ---------------------------------------------------------------------------
// ibuf_pingpong_if
// Bundles the memory-side write port, the bank fill/drain handshakes and the
// array-side read port of the ping-pong input buffer.
//
// Signals (widths derive from the parameters):
//   mem_write_req / mem_write_addr / mem_write_data : write strobe into fill bank
//   fill_ready / fill_done                          : fill-bank handshake
//   buf_read_req / buf_read_addr                    : lane-0 read request
//   read_ready / read_done                          : read-bank handshake
//   buf_read_data / buf_read_valid                  : per-lane skewed read results
// Modports: master drives requests and consumes results; slave is the buffer.
// ---------------------------------------------------------------------------
interface ibuf_pingpong_if #(
    parameter int ARRAY_N        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 10
);
    localparam int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH;
    localparam int GROUP_ID_W     = (GROUP_SIZE == 1) ? 0 : $clog2(GROUP_SIZE);
    localparam int BUF_ID_W       = $clog2(ARRAY_N) - GROUP_ID_W;
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;

    logic                          mem_write_req;
    logic [MEM_ADDR_WIDTH-1:0]     mem_write_addr;
    logic [MEM_DATA_WIDTH-1:0]     mem_write_data;
    logic                          fill_ready;
    logic                          fill_done;
    logic                          buf_read_req;
    logic [BUF_ADDR_WIDTH-1:0]     buf_read_addr;
    logic                          read_ready;
    logic                          read_done;
    logic [ARRAY_N*DATA_WIDTH-1:0] buf_read_data;
    logic [ARRAY_N-1:0]            buf_read_valid;

    modport master (
        output mem_write_req, mem_write_addr, mem_write_data, fill_done,
               buf_read_req, buf_read_addr, read_done,
        input  fill_ready, read_ready, buf_read_data, buf_read_valid
    );

    modport slave (
        input  mem_write_req, mem_write_addr, mem_write_data, fill_done,
               buf_read_req, buf_read_addr, read_done,
        output fill_ready, read_ready, buf_read_data, buf_read_valid
    );
endinterface

// File: rtl/ibuf_pingpong.sv
// ---------------------------------------------------------------------------
// ibuf_pingpong
// Double-buffered input buffer for an ARRAY_N-lane systolic array. One bank is
// filled from the memory write port while the other is read by the array, so
// loading tile k+1 overlaps compute on tile k. Lane read requests are skewed
// one cycle per lane; each lane returns data two cycles after it sees the
// request (one synchronous SRAM cycle plus one output register).
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : ibuf_pingpong_if.slave (write port, fill/read handshakes, read port)
// Requires ARRAY_N >= 2.
// ---------------------------------------------------------------------------
module ibuf_pingpong #(
    parameter int ARRAY_N        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 10
) (
    input  logic           clk,
    input  logic           reset,
    ibuf_pingpong_if.slave bus
);
    localparam int GROUP_SIZE = MEM_DATA_WIDTH / DATA_WIDTH;
    localparam int GROUP_ID_W = (GROUP_SIZE == 1) ? 0 : $clog2(GROUP_SIZE);
    localparam int BUF_ID_W   = $clog2(ARRAY_N) - GROUP_ID_W;
    localparam int DEPTH      = 2 ** BUF_ADDR_WIDTH;

    // Bank ownership: full_q[b] marks bank b as holding a complete tile.
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] full_q, full_d;
    logic       fill_ready, read_ready;
    logic       wr_fire, rd_fire;

    logic [BUF_ADDR_WIDTH-1:0] wr_local;
    logic [31:0]               wr_buf_id;

    // Per-lane view of the read request after skewing.
    logic [ARRAY_N-1:0]        lane_req;
    logic [ARRAY_N-1:0]        lane_bank;
    logic [BUF_ADDR_WIDTH-1:0] lane_addr [ARRAY_N];

    // Skew registers: entry n holds lane n's {req, addr, bank}.
    logic                      skew_req_q  [1:ARRAY_N-1];
    logic                      skew_req_d  [1:ARRAY_N-1];
    logic [BUF_ADDR_WIDTH-1:0] skew_addr_q [1:ARRAY_N-1];
    logic [BUF_ADDR_WIDTH-1:0] skew_addr_d [1:ARRAY_N-1];
    logic                      skew_bank_q [1:ARRAY_N-1];
    logic                      skew_bank_d [1:ARRAY_N-1];

    logic [ARRAY_N*DATA_WIDTH-1:0] read_data_all;
    logic [ARRAY_N-1:0]            read_valid_all;

    // Both handshakes are judged on pre-edge state. When both are legal they
    // necessarily target different banks (one empty, one full).
    always_comb begin
        fill_ready = ~full_q[wr_sel_q];
        read_ready = full_q[rd_sel_q];
        wr_fire    = bus.mem_write_req && fill_ready;
        rd_fire    = bus.buf_read_req && read_ready;
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        if (bus.fill_done && fill_ready) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (bus.read_done && read_ready) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= 2'b00;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
        end
    end

    // Write address is {local_addr, buf_id} with buf_id in the LSBs.
    always_comb begin
        wr_local  = BUF_ADDR_WIDTH'(bus.mem_write_addr >> BUF_ID_W);
        wr_buf_id = 32'(bus.mem_write_addr) & ((32'd1 << BUF_ID_W) - 32'd1);
    end

    // Lane 0 takes the request directly; the bank is captured at acceptance so
    // a later read_done cannot redirect lanes still in flight.
    always_comb begin
        lane_req[0]  = rd_fire;
        lane_addr[0] = bus.buf_read_addr;
        lane_bank[0] = rd_sel_q;
        for (int n = 1; n < ARRAY_N; n++) begin
            lane_req[n]  = skew_req_q[n];
            lane_addr[n] = skew_addr_q[n];
            lane_bank[n] = skew_bank_q[n];
        end
    end

    always_comb begin
        for (int n = 1; n < ARRAY_N; n++) begin
            skew_req_d[n]  = lane_req[n-1];
            skew_addr_d[n] = lane_addr[n-1];
            skew_bank_d[n] = lane_bank[n-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 1; n < ARRAY_N; n++) begin
            if (reset) begin
                skew_req_q[n] <= 1'b0;
            end else begin
                skew_req_q[n] <= skew_req_d[n];
            end
            skew_addr_q[n] <= skew_addr_d[n];
            skew_bank_q[n] <= skew_bank_d[n];
        end
    end

    for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
        logic [DATA_WIDTH-1:0] bank_mem [2][DEPTH];
        logic                  lane_sel;
        logic                  lane_wr_en;
        logic [DATA_WIDTH-1:0] lane_wr_data;
        logic                  rd_vld_q, rd_vld_d;
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  out_vld_q, out_vld_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

        // With no lane-group field every write reaches all lanes.
        if (BUF_ID_W == 0) begin : g_all
            assign lane_sel = 1'b1;
        end else begin : g_grp
            assign lane_sel = (wr_buf_id == 32'(n / GROUP_SIZE));
        end

        always_comb begin
            lane_wr_en   = wr_fire && lane_sel;
            lane_wr_data = bus.mem_write_data[(n % GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH];
            rd_vld_d     = lane_req[n];
            rd_data_d    = bank_mem[lane_bank[n]][lane_addr[n]];
            out_vld_d    = rd_vld_q;
            out_data_d   = rd_vld_q ? rd_data_q : out_data_q;
        end

        always_ff @(posedge clk) begin
            if (lane_wr_en) begin
                bank_mem[wr_sel_q][wr_local] <= lane_wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_vld_q   <= 1'b0;
                out_vld_q  <= 1'b0;
                out_data_q <= '0;
            end else begin
                rd_vld_q   <= rd_vld_d;
                out_vld_q  <= out_vld_d;
                out_data_q <= out_data_d;
            end
            rd_data_q <= rd_data_d;
        end

        assign read_data_all[n*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
        assign read_valid_all[n]                         = out_vld_q;
    end

    assign bus.fill_ready     = fill_ready;
    assign bus.read_ready     = read_ready;
    assign bus.buf_read_data  = read_data_all;
    assign bus.buf_read_valid = read_valid_all;
endmodule
